apb_csr_ctrl: RTL and testbench

APB3 slave controller for the 8 x 8-bit CSR bank. It decodes APB transfers, holds the register bank and drives the select/enable of the external 8:1 read mux. It captures the mux output into PRDATA and commits writes. It inserts a programmable number of wait states and flags bad accesses with PSLVERR.

---
 rtl/apb_csr_ctrl.sv | 121 ++++++++++++
 tb/tb_apb_csr_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_csr_ctrl.sv
// APB3 slave for an 8 x 8-bit CSR bank with an external 8:1 read mux and programmable wait states.
// Optional build macro CSR_LOCK_EN: reg6 bit0 becomes a sticky write-lock for regs 0..5.
module apb_csr_ctrl #(
  parameter int         WAIT_CYC = 1,
  parameter logic [7:0] ID_VAL   = 8'hA5,
  parameter int         PADDR_W  = 5
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [7:0]         pwdata,
  output logic [7:0]         prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [63:0]        csr_q,
  output logic [2:0]         csr_sel,
  output logic               csr_en,
  input  logic [7:0]         rd_data_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  typedef struct packed {
    logic               wr;
    logic [PADDR_W-1:0] addr;
    logic [7:0]         wdata;
  } req_t;

  req_t            req;
  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [6:0][7:0] regs;
  logic [2:0]      idx;
  logic            hi_err;
  logic            lock_err;
  logic            err;

  assign idx = req.addr[4:2];

  if (PADDR_W > 5) begin : g_hi
    assign hi_err = |req.addr[PADDR_W-1:5];
  end else begin : g_nohi
    assign hi_err = 1'b0;
  end

`ifdef CSR_LOCK_EN
  assign lock_err = req.wr && regs[6][0] && (idx < 3'd6);
`else
  assign lock_err = 1'b0;
`endif

  assign err = (req.addr[1:0] != 2'b00) | hi_err | (req.wr && idx == 3'd7) | lock_err;

  // Register 7 has no storage; its mux slot is tied low and ID_VAL is substituted on read.
  assign csr_q = {8'h00, regs};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= S_IDLE;
      req     <= '0;
      cnt     <= '0;
      regs    <= '0;
      csr_sel <= '0;
      csr_en  <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && !penable) begin
            req     <= '{wr: pwrite, addr: paddr, wdata: pwdata};
            csr_sel <= paddr[4:2];
            csr_en  <= 1'b1;
            cnt     <= 4'(WAIT_CYC - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!psel) begin
            csr_en <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= (!req.wr && !err) ? ((idx == 3'd7) ? ID_VAL : rd_data_i) : 8'h00;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          csr_en  <= 1'b0;
          state   <= S_IDLE;
          // pslverr still holds this transfer's verdict here
          if (req.wr && !pslverr) begin
            for (int i = 0; i < 7; i++) begin
              if (idx == 3'(i)) begin
`ifdef CSR_LOCK_EN
                if (i == 6) regs[i] <= {req.wdata[7:1], regs[i][0] | req.wdata[0]};
                else
`endif
                regs[i] <= req.wdata;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_csr_ctrl.sv
// Randomized APB bench for apb_csr_ctrl, checked every cycle against a transaction-level bank model.
module tb_apb_csr_ctrl;
  localparam int WAIT = 1;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pready, pslverr;
  logic [63:0] csr_q;
  logic [2:0]  csr_sel;
  logic        csr_en;
  logic [7:0]  rd_data_i;

  apb_csr_ctrl #(.WAIT_CYC(WAIT), .ID_VAL(8'hA5), .PADDR_W(5)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .csr_q(csr_q), .csr_sel(csr_sel), .csr_en(csr_en), .rd_data_i(rd_data_i)
  );

  // external 8:1 mux fed from the bank
  assign rd_data_i = csr_en ? csr_q[{csr_sel, 3'b000} +: 8] : 8'h00;

  always #5 pclk = ~pclk;

  int checks = 0, failures = 0;

  // transaction-level model
  logic [7:0] mem [0:7];
  logic       e_rdy, e_err, e_en;
  logic [7:0] e_rd;
  logic [2:0] e_sel;
  bit         chk_en = 0;
  logic [7:0] got_rd;
  logic       got_err, got_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_q();
    return {8'h00, mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
  endfunction

  function automatic bit exp_err(input bit wr, input logic [4:0] a);
    bit e;
    e = (a[1:0] != 2'b00) || (wr && a[4:2] == 3'd7);
`ifdef CSR_LOCK_EN
    e = e || (wr && a[4:2] < 3'd6 && mem[6][0]);
`endif
    return e;
  endfunction

  task automatic model_write(input logic [2:0] ix, input logic [7:0] d);
`ifdef CSR_LOCK_EN
    if (ix == 3'd6) begin
      mem[6] = {d[7:1], mem[6][0] | d[0]};
      return;
    end
`endif
    mem[ix] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    e_sel = 3'd0;
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("pready", pready, e_rdy);
      chk("pslverr", pslverr, e_err);
      chk("prdata", prdata, e_rd);
      chk("csr_en", csr_en, e_en);
      chk("csr_sel", csr_sel, e_sel);
      chk("csr_q", csr_q, model_q());
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_rdy = 1'b0; e_err = 1'b0; e_rd = 8'h00; e_en = 1'b0;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    set_idle_exp();
    step();
  endtask

  task automatic xfer(input bit wr, input logic [4:0] a, input logic [7:0] d, input bit abort);
    bit         e;
    logic [2:0] ix;
    logic [7:0] r;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    set_idle_exp();
    step();
    ix = a[4:2];
    e  = exp_err(wr, a);
    r  = (wr || e) ? 8'h00 : ((ix == 3'd7) ? 8'hA5 : mem[ix]);
    e_sel = ix; e_en = 1'b1;
    for (int k = 1; k <= WAIT; k++) begin
      if (abort && k == WAIT) begin psel = 1'b0; penable = 1'b0; end
      else penable = 1'b1;
      step();
      if (abort && k == WAIT) begin
        set_idle_exp();
        got_rdy = 1'b0;
        return;
      end
    end
    e_rdy = 1'b1; e_err = e; e_rd = r;
    #4;
    got_rd = prdata; got_err = pslverr; got_rdy = pready;
    @(posedge pclk);
    #1;
    if (wr && !e) model_write(ix, d);
    psel = 1'b0; penable = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] q0;
    logic [4:0]  a;
    model_clear();
    set_idle_exp();
    #1 presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_csr_q", csr_q, 64'h0);
    chk("rst_csr_en", csr_en, 1'b0);
    chk("rst_csr_sel", csr_sel, 3'd0);
    presetn = 1'b1;
    chk_en = 1;
    idle();

    xfer(1, 5'h08, 8'h3C, 0);
    chk("wr08_rdy", got_rdy, 1'b1);
    chk("wr08_err", got_err, 1'b0);
    chk("wr08_q", csr_q[23:16], 8'h3C);
    xfer(0, 5'h08, 8'h00, 0);
    chk("rd08", got_rd, 8'h3C);
    xfer(0, 5'h1C, 8'h00, 0);
    chk("rd_id", got_rd, 8'hA5);
    chk("rd_id_err", got_err, 1'b0);

    q0 = csr_q;
    xfer(1, 5'h1C, 8'h55, 0);
    chk("wr_id_err", got_err, 1'b1);
    chk("wr_id_rd", got_rd, 8'h00);
    xfer(1, 5'h05, 8'h66, 0);
    chk("misalign_err", got_err, 1'b1);
    chk("misalign_q", csr_q, q0);
    xfer(0, 5'h0A, 8'h00, 0);
    chk("misalign_rd", got_rd, 8'h00);

    xfer(1, 5'h00, 8'h11, 0);
    xfer(0, 5'h00, 8'h00, 0);
    chk("b2b_rd", got_rd, 8'h11);
    xfer(1, 5'h08, 8'h99, 1);
    idle();
    chk("abort_q", csr_q[23:16], 8'h3C);

    // penable without setup must be ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h04; pwdata = 8'hEE;
    set_idle_exp();
    step(); step();
    idle();

    for (int n = 0; n < 300; n++) begin
      a = {3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle();
    end

    // reset during WAIT of a write to reg2
    chk_en = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h08; pwdata = 8'h77;
    step();
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    chk("midrst_q", csr_q, 64'h0);
    chk("midrst_rdy", pready, 1'b0);
    chk("midrst_en", csr_en, 1'b0);
    step();
    psel = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    model_clear();
    set_idle_exp();
    chk_en = 1;
    step();
    chk("midrst_reg2", csr_q[23:16], 8'h00);
    xfer(0, 5'h08, 8'h00, 0);
    chk("midrst_rd2", got_rd, 8'h00);

`ifdef CSR_LOCK_EN
    xfer(1, 5'h18, 8'h01, 0);
    xfer(1, 5'h00, 8'hFF, 0);
    chk("lock_err", got_err, 1'b1);
    chk("lock_reg0", csr_q[7:0], 8'h00);
    xfer(1, 5'h18, 8'h00, 0);
    chk("lock_sticky", csr_q[48], 1'b1);
    xfer(1, 5'h18, 8'hFE, 0);
    chk("lock_hi_bits", csr_q[55:48], 8'hFF);
`else
    xfer(1, 5'h18, 8'h01, 0);
    xfer(1, 5'h18, 8'h00, 0);
    chk("reg6_plain", csr_q[55:48], 8'h00);
    xfer(1, 5'h00, 8'hFF, 0);
    chk("reg0_wr_err", got_err, 1'b0);
    chk("reg0_wr", csr_q[7:0], 8'hFF);
`endif
    idle();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
